// File: rtl/obuf_tag_scheduler.sv
// In-order round-robin tag scheduler for the multi-buffered output buffer.
// Routes global ldmem/compute/stmem handshakes to the owning tag_logic lane.
module obuf_tag_scheduler #(
    parameter int NUM_TAGS      = 2,
    parameter int TAG_W         = 1,
    parameter int STORE_ENABLED = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tag_req,
    input  logic                tag_reuse,
    input  logic                tag_flush,
    output logic                tag_ready,
    output logic [TAG_W-1:0]    cur_tag,
    output logic [NUM_TAGS-1:0] per_tag_req,
    output logic [NUM_TAGS-1:0] per_tag_reuse,
    output logic [NUM_TAGS-1:0] per_tag_flush,
    input  logic [NUM_TAGS-1:0] per_tag_free,
    input  logic [NUM_TAGS-1:0] per_tag_ldmem_ready,
    input  logic [NUM_TAGS-1:0] per_tag_compute_ready,
    input  logic [NUM_TAGS-1:0] per_tag_next_compute,
    input  logic [NUM_TAGS-1:0] per_tag_stmem_ready,
    input  logic                ldmem_tag_done,
    input  logic                compute_tag_done,
    input  logic                stmem_tag_done,
    output logic [NUM_TAGS-1:0] per_tag_ldmem_done,
    output logic [NUM_TAGS-1:0] per_tag_compute_done,
    output logic [NUM_TAGS-1:0] per_tag_stmem_done,
    output logic [TAG_W-1:0]    ldmem_tag,
    output logic [TAG_W-1:0]    compute_tag,
    output logic [TAG_W-1:0]    stmem_tag,
    output logic                ldmem_ready,
    output logic                compute_ready,
    output logic                stmem_ready,
    output logic [TAG_W:0]      busy_count,
    output logic                all_idle,
    output logic                proto_err
);

    localparam logic [TAG_W-1:0]    LAST_TAG = TAG_W'(NUM_TAGS - 1);
    localparam logic [TAG_W:0]      FULL_CNT = (TAG_W + 1)'(NUM_TAGS);
    localparam logic [NUM_TAGS-1:0] LANE0    = NUM_TAGS'(1);
    localparam logic                STORE_ON = (STORE_ENABLED != 0);

    logic [TAG_W-1:0] r_alloc_ptr;
    logic [TAG_W-1:0] r_ldmem_ptr;
    logic [TAG_W-1:0] r_compute_ptr;
    logic [TAG_W-1:0] r_stmem_ptr;
    logic [TAG_W-1:0] r_cur_tag;
    logic [TAG_W:0]   r_busy;
    logic             r_err;

    logic w_run;
    logic w_busy_nz;
    logic w_accept;
    logic w_reuse_go;
    logic w_flush_go;
    logic w_ld_go;
    logic w_cmp_go;
    logic w_next_cmp;
    logic w_st_go;
    logic w_dec;
    logic w_err;

    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
        return (p == LAST_TAG) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [NUM_TAGS-1:0] lane(input logic [TAG_W-1:0] p);
        return LANE0 << p;
    endfunction

    // Routed strobes are suppressed while reset is held so the lanes see nothing.
    always_comb begin
        w_run         = !reset;
        w_busy_nz     = (r_busy != '0);
        tag_ready     = w_run && per_tag_free[r_alloc_ptr] && (r_busy < FULL_CNT);
        w_accept      = tag_req && tag_ready;
        w_reuse_go    = w_run && tag_reuse && w_busy_nz;
        w_flush_go    = w_run && tag_flush && w_busy_nz;

        ldmem_ready   = per_tag_ldmem_ready[r_ldmem_ptr];
        compute_ready = per_tag_compute_ready[r_compute_ptr];
        stmem_ready   = STORE_ON ? per_tag_stmem_ready[r_stmem_ptr] : 1'b0;

        w_ld_go       = w_run && ldmem_tag_done && ldmem_ready;
        w_cmp_go      = w_run && compute_tag_done && compute_ready;
        w_next_cmp    = w_run && per_tag_next_compute[r_compute_ptr];
        w_st_go       = w_run && stmem_tag_done && stmem_ready;
        w_dec         = STORE_ON ? w_st_go : w_next_cmp;

        // A decrement paired with an accept is a legal hand-over even at zero.
        w_err = ((tag_reuse || tag_flush) && !w_busy_nz)
              || (ldmem_tag_done && !ldmem_ready)
              || (STORE_ON && stmem_tag_done && !stmem_ready)
              || (w_dec && !w_accept && !w_busy_nz);

        per_tag_req          = w_accept   ? lane(r_alloc_ptr)   : '0;
        per_tag_reuse        = w_reuse_go ? lane(r_cur_tag)     : '0;
        per_tag_flush        = w_flush_go ? lane(r_cur_tag)     : '0;
        per_tag_ldmem_done   = w_ld_go    ? lane(r_ldmem_ptr)   : '0;
        per_tag_compute_done = w_cmp_go   ? lane(r_compute_ptr) : '0;
        per_tag_stmem_done   = w_st_go    ? lane(r_stmem_ptr)   : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alloc_ptr   <= '0;
            r_ldmem_ptr   <= '0;
            r_compute_ptr <= '0;
            r_stmem_ptr   <= '0;
            r_cur_tag     <= '0;
            r_busy        <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_tag   <= r_alloc_ptr;
                r_alloc_ptr <= next_ptr(r_alloc_ptr);
            end
            if (w_ld_go)    r_ldmem_ptr   <= next_ptr(r_ldmem_ptr);
            if (w_next_cmp) r_compute_ptr <= next_ptr(r_compute_ptr);
            if (w_st_go)    r_stmem_ptr   <= next_ptr(r_stmem_ptr);

            if (w_accept && !w_dec)
                r_busy <= r_busy + 1'b1;
            else if (w_dec && !w_accept && w_busy_nz)
                r_busy <= r_busy - 1'b1;

            if (w_err) r_err <= 1'b1;
        end
    end

    assign cur_tag     = r_cur_tag;
    assign ldmem_tag   = r_ldmem_ptr;
    assign compute_tag = r_compute_ptr;
    assign stmem_tag   = r_stmem_ptr;
    assign busy_count  = r_busy;
    assign all_idle    = reset || (r_busy == '0);
    assign proto_err   = r_err;

endmodule

// File: tb/tb_obuf_tag_scheduler.sv
// Scoreboard bench: dut_a (2 tags, store on) and dut_b (3 tags, store off).
// Expected lane strobes are queued at stimulus time and popped when seen.
module tb_obuf_tag_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stream ids: 0 a_req 1 a_reuse 2 a_flush 3 a_ld 4 a_cmp 5 a_st 6 b_req 7 b_cmp 8 b_st 9 b_ld
    logic [31:0] sb_q[10][$];

    // ---------------- dut_a signals ----------------
    logic       a_req = 0, a_reuse = 0, a_flush = 0;
    logic       a_ld_done = 0, a_c_done = 0, a_s_done = 0;
    logic [1:0] a_free = 2'b11, a_ldr = 0, a_cr = 0, a_nc = 0, a_sr = 0;
    logic       a_tag_ready, a_ldmem_ready, a_compute_ready, a_stmem_ready, a_all_idle, a_err;
    logic [0:0] a_cur_tag, a_ldmem_tag, a_compute_tag, a_stmem_tag;
    logic [1:0] a_p_req, a_p_reuse, a_p_flush, a_p_ld, a_p_c, a_p_s, a_busy;

    obuf_tag_scheduler #(.NUM_TAGS(2), .TAG_W(1), .STORE_ENABLED(1)) dut_a (
        .clk(clk), .reset(reset),
        .tag_req(a_req), .tag_reuse(a_reuse), .tag_flush(a_flush),
        .tag_ready(a_tag_ready), .cur_tag(a_cur_tag),
        .per_tag_req(a_p_req), .per_tag_reuse(a_p_reuse), .per_tag_flush(a_p_flush),
        .per_tag_free(a_free), .per_tag_ldmem_ready(a_ldr),
        .per_tag_compute_ready(a_cr), .per_tag_next_compute(a_nc),
        .per_tag_stmem_ready(a_sr),
        .ldmem_tag_done(a_ld_done), .compute_tag_done(a_c_done), .stmem_tag_done(a_s_done),
        .per_tag_ldmem_done(a_p_ld), .per_tag_compute_done(a_p_c), .per_tag_stmem_done(a_p_s),
        .ldmem_tag(a_ldmem_tag), .compute_tag(a_compute_tag), .stmem_tag(a_stmem_tag),
        .ldmem_ready(a_ldmem_ready), .compute_ready(a_compute_ready), .stmem_ready(a_stmem_ready),
        .busy_count(a_busy), .all_idle(a_all_idle), .proto_err(a_err)
    );

    // ---------------- dut_b signals ----------------
    logic       b_req = 0, b_reuse = 0, b_flush = 0;
    logic       b_ld_done = 0, b_c_done = 0, b_s_done = 0;
    logic [2:0] b_free = 3'b111, b_ldr = 0, b_cr = 0, b_nc = 0, b_sr = 0;
    logic       b_tag_ready, b_ldmem_ready, b_compute_ready, b_stmem_ready, b_all_idle, b_err;
    logic [1:0] b_cur_tag, b_ldmem_tag, b_compute_tag, b_stmem_tag;
    logic [2:0] b_p_req, b_p_reuse, b_p_flush, b_p_ld, b_p_c, b_p_s, b_busy;

    obuf_tag_scheduler #(.NUM_TAGS(3), .TAG_W(2), .STORE_ENABLED(0)) dut_b (
        .clk(clk), .reset(reset),
        .tag_req(b_req), .tag_reuse(b_reuse), .tag_flush(b_flush),
        .tag_ready(b_tag_ready), .cur_tag(b_cur_tag),
        .per_tag_req(b_p_req), .per_tag_reuse(b_p_reuse), .per_tag_flush(b_p_flush),
        .per_tag_free(b_free), .per_tag_ldmem_ready(b_ldr),
        .per_tag_compute_ready(b_cr), .per_tag_next_compute(b_nc),
        .per_tag_stmem_ready(b_sr),
        .ldmem_tag_done(b_ld_done), .compute_tag_done(b_c_done), .stmem_tag_done(b_s_done),
        .per_tag_ldmem_done(b_p_ld), .per_tag_compute_done(b_p_c), .per_tag_stmem_done(b_p_s),
        .ldmem_tag(b_ldmem_tag), .compute_tag(b_compute_tag), .stmem_tag(b_stmem_tag),
        .ldmem_ready(b_ldmem_ready), .compute_ready(b_compute_ready), .stmem_ready(b_stmem_ready),
        .busy_count(b_busy), .all_idle(b_all_idle), .proto_err(b_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input int k);
        logic [31:0] one;
        one = 32'd1;
        return one << k;
    endfunction

    task automatic sb_pop(input int s, input string tag, input logic [31:0] got);
        if (sb_q[s].size() == 0) check_val({tag, "_unexpected"}, got, 32'd0);
        else                     check_val(tag, got, sb_q[s].pop_front());
    endtask

    // Monitor: any routed strobe is output the scoreboard must account for.
    always @(negedge clk) begin
        if (a_p_req   != 0) sb_pop(0, "a_req",   32'(a_p_req));
        if (a_p_reuse != 0) sb_pop(1, "a_reuse", 32'(a_p_reuse));
        if (a_p_flush != 0) sb_pop(2, "a_flush", 32'(a_p_flush));
        if (a_p_ld    != 0) sb_pop(3, "a_ld",    32'(a_p_ld));
        if (a_p_c     != 0) sb_pop(4, "a_cmp",   32'(a_p_c));
        if (a_p_s     != 0) sb_pop(5, "a_st",    32'(a_p_s));
        if (b_p_req   != 0) sb_pop(6, "b_req",   32'(b_p_req));
        if (b_p_c     != 0) sb_pop(7, "b_cmp",   32'(b_p_c));
        if (b_p_s     != 0) sb_pop(8, "b_st",    32'(b_p_s));
        if (b_p_ld    != 0 || b_p_reuse != 0 || b_p_flush != 0)
            sb_pop(9, "b_other", 32'({b_p_ld, b_p_reuse, b_p_flush}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        a_req = 0; a_reuse = 0; a_flush = 0; a_ld_done = 0; a_c_done = 0; a_s_done = 0; a_nc = 0;
        b_req = 0; b_reuse = 0; b_flush = 0; b_ld_done = 0; b_c_done = 0; b_s_done = 0; b_nc = 0;
    endtask

    initial begin
        // ---- reset: strobes suppressed, idle reported ----
        reset = 1; a_req = 1; b_req = 1;
        tick(); tick();
        #2;
        check_val("rst_a_req_lane", 32'(a_p_req), 0);
        check_val("rst_a_idle", 32'(a_all_idle), 1);
        check_val("rst_b_idle", 32'(b_all_idle), 1);
        clear_pulses();
        tick();
        reset = 0;
        #2;
        check_val("rst_cur_tag", 32'(a_cur_tag), 0);
        check_val("rst_busy", 32'(a_busy), 0);
        check_val("rst_err", 32'(a_err), 0);
        check_val("rst_tag_ready", 32'(a_tag_ready), 1);

        // ---- dut_a: two back-to-back allocations, third held off ----
        a_req = 1; sb_q[0].push_back(onehot(0));
        tick();
        check_val("alloc1_cur", 32'(a_cur_tag), 0);
        check_val("alloc1_busy", 32'(a_busy), 1);
        sb_q[0].push_back(onehot(1));
        tick();
        check_val("alloc2_cur", 32'(a_cur_tag), 1);
        check_val("alloc2_busy", 32'(a_busy), 2);
        #2;
        check_val("full_tag_ready", 32'(a_tag_ready), 0);
        tick();
        a_req = 0;
        check_val("full_busy_hold", 32'(a_busy), 2);
        check_val("full_cur_hold", 32'(a_cur_tag), 1);

        // ---- reuse / flush routed to cur_tag ----
        a_reuse = 1; sb_q[1].push_back(onehot(1));
        tick(); a_reuse = 0;
        a_flush = 1; sb_q[2].push_back(onehot(1));
        tick(); a_flush = 0;
        check_val("reuse_no_err", 32'(a_err), 0);

        // ---- ldmem ----
        a_ldr = 2'b01; a_ld_done = 1; sb_q[3].push_back(onehot(0));
        #2; check_val("ld_ready", 32'(a_ldmem_ready), 1);
        tick();
        check_val("ld_tag1", 32'(a_ldmem_tag), 1);
        a_ldr = 2'b10; sb_q[3].push_back(onehot(1));
        tick();
        a_ld_done = 0; a_ldr = 0;
        check_val("ld_tag_wrap", 32'(a_ldmem_tag), 0);

        // ---- compute: two passes stay on tag 0, then release ----
        a_cr = 2'b01; a_c_done = 1; sb_q[4].push_back(onehot(0));
        tick();
        sb_q[4].push_back(onehot(0));
        tick();
        a_c_done = 0;
        check_val("cmp_tag_stays", 32'(a_compute_tag), 0);
        a_nc = 2'b01;
        tick();
        a_nc = 0; a_cr = 0;
        check_val("cmp_tag_adv", 32'(a_compute_tag), 1);
        check_val("cmp_busy_keep", 32'(a_busy), 2);

        // ---- stmem retires ----
        a_sr = 2'b01; a_s_done = 1; sb_q[5].push_back(onehot(0));
        tick();
        check_val("st_busy1", 32'(a_busy), 1);
        check_val("st_tag1", 32'(a_stmem_tag), 1);
        a_sr = 2'b10; sb_q[5].push_back(onehot(1));
        tick();
        a_s_done = 0; a_sr = 0;
        check_val("st_busy0", 32'(a_busy), 0);
        check_val("st_idle", 32'(a_all_idle), 1);
        check_val("st_no_err", 32'(a_err), 0);

        // ---- error: ldmem done while not ready, sticky ----
        a_ld_done = 1;
        tick();
        a_ld_done = 0;
        check_val("ld_err", 32'(a_err), 1);
        check_val("ld_err_ptr_hold", 32'(a_ldmem_tag), 0);
        tick(); tick();
        check_val("ld_err_sticky", 32'(a_err), 1);

        // ---- error: reuse with nothing allocated ----
        reset = 1; tick(); reset = 0;
        check_val("err_cleared", 32'(a_err), 0);
        a_reuse = 1;
        tick();
        a_reuse = 0;
        check_val("reuse_idle_err", 32'(a_err), 1);

        // ---- mid-operation reset ----
        reset = 1; tick(); reset = 0;
        a_req = 1; sb_q[0].push_back(onehot(0));
        tick();
        sb_q[0].push_back(onehot(1));
        tick();
        a_req = 0;
        a_ldr = 2'b01; a_ld_done = 1; sb_q[3].push_back(onehot(0));
        tick();
        check_val("mid_ld_tag", 32'(a_ldmem_tag), 1);
        reset = 1; a_ldr = 2'b10;
        #2;
        check_val("mid_rst_idle", 32'(a_all_idle), 1);
        tick();
        reset = 0; a_ld_done = 0; a_ldr = 0;
        check_val("mid_rst_ld_tag", 32'(a_ldmem_tag), 0);
        check_val("mid_rst_cur", 32'(a_cur_tag), 0);
        check_val("mid_rst_busy", 32'(a_busy), 0);
        check_val("mid_rst_idle_after", 32'(a_all_idle), 1);

        // ---- dut_b: 3 tags, wrap, retire on compute release ----
        b_sr = 3'b111;
        for (int k = 0; k < 4; k++) begin
            b_req = 1; b_s_done = 1;
            sb_q[6].push_back(onehot(k % 3));
            b_nc = (k > 0) ? 3'(onehot((k - 1) % 3)) : 3'b000;
            #2;
            check_val("b_stmem_ready", 32'(b_stmem_ready), 0);
            tick();
            check_val("b_cur_tag", 32'(b_cur_tag), 32'(k % 3));
            check_val("b_busy_hold", 32'(b_busy), 1);
            check_val("b_cmp_tag", 32'(b_compute_tag), 32'(k % 3));
        end
        b_req = 0; b_s_done = 0; b_sr = 0;
        b_nc = 3'b001;
        tick();
        b_nc = 0;
        check_val("b_busy0", 32'(b_busy), 0);
        check_val("b_idle", 32'(b_all_idle), 1);
        check_val("b_stmem_tag", 32'(b_stmem_tag), 0);
        check_val("b_no_err", 32'(b_err), 0);
        b_nc = 3'b010;
        tick();
        b_nc = 0;
        check_val("b_underflow_err", 32'(b_err), 1);
        check_val("b_underflow_sat", 32'(b_busy), 0);

        tick(); tick();
        for (int s = 0; s < 10; s++)
            check_val("sb_leftover", 32'(sb_q[s].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
